// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types.
//   lc3b_word   : 16-bit line address
//   lc3b_block  : 128-bit cache line
//   arb_state_t : L1 memory arbiter FSM states
//   arb_op_t    : latched memory operation
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;
endpackage

// File: rtl/arb_req_latch.sv
// Registered capture of one memory request (address, write data, op).
//   clk, rst_n            : clock, async active-low reset
//   load                  : capture nxt_* on this edge
//   nxt_addr/wdata/op     : request to capture
//   addr/wdata/op         : held request, stable until the next load
module arb_req_latch
  import lc3b_types::*;
#(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(lc3b_block)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] nxt_addr,
  input  logic [LINE_W-1:0] nxt_wdata,
  input  arb_op_t           nxt_op,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] wdata,
  output arb_op_t           op
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      wdata <= '0;
      op    <= OP_READ;
    end else if (load) begin
      addr  <= nxt_addr;
      wdata <= nxt_wdata;
      op    <= nxt_op;
    end
  end
endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter multiplexing the icache and dcache pmem ports onto
// a single memory port, one whole line transaction at a time.
//   clk, rst_n        : clock, async active-low reset
//   i_pmem_*          : icache fill request / completion
//   d_pmem_*          : dcache fill + writeback request / completion
//   mem_*             : downstream memory port (strobes held until mem_resp)
// The winner is latched on the granting edge; memory strobes come from
// that latch so client input changes during a grant are invisible.
module l1_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(lc3b_block)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);
  arb_state_t        state, state_nxt;
  logic              prio, prio_nxt;   // 0: icache preferred, 1: dcache
  logic              busy;             // memory strobe active
  logic              load, sel_d, req_i, req_d;
  logic [ADDR_W-1:0] nxt_addr;
  logic [LINE_W-1:0] nxt_wdata;
  arb_op_t           nxt_op, op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      if (load)                           busy <= 1'b1;
      else if (i_pmem_resp | d_pmem_resp) busy <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    prio_nxt    = prio;
    load        = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    req_i       = i_pmem_read;
    req_d       = d_pmem_read | d_pmem_write;
    case (state)
      IDLE: begin
        if (req_i && (!req_d || !prio)) begin
          state_nxt = GRANT_I;
          load      = 1'b1;
        end else if (req_d) begin
          state_nxt = GRANT_D;
          load      = 1'b1;
        end
      end
      GRANT_I: if (mem_resp) begin
        i_pmem_resp = 1'b1;
        prio_nxt    = 1'b1;
        state_nxt   = RELEASE;
      end
      GRANT_D: if (mem_resp) begin
        d_pmem_resp = 1'b1;
        prio_nxt    = 1'b0;
        state_nxt   = RELEASE;
      end
      // bubble so a stale level request is not re-granted
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // read+write together from the dcache is illegal; write wins
  always_comb begin
    sel_d     = (state_nxt == GRANT_D);
    nxt_addr  = sel_d ? d_pmem_address : i_pmem_address;
    nxt_wdata = sel_d ? d_pmem_wdata : '0;
    nxt_op    = (sel_d && d_pmem_write) ? OP_WRITE : OP_READ;
  end

  arb_req_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .nxt_addr  (nxt_addr),
    .nxt_wdata (nxt_wdata),
    .nxt_op    (nxt_op),
    .addr      (mem_address),
    .wdata     (mem_wdata),
    .op        (op)
  );

  assign mem_read     = busy && (op == OP_READ);
  assign mem_write    = busy && (op == OP_WRITE);
  // ungranted side sees rdata too; its resp stays low
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  a_d_rw_illegal: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write))
    else $warning("dcache read and write both high; issued as write");
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));
  a_resp_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pmem_resp && d_pmem_resp));
endmodule

// File: tb/tb_l1_mem_arbiter.sv
module tb_l1_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         i_pmem_read = 1'b0, d_pmem_read = 1'b0, d_pmem_write = 1'b0;
  logic [15:0]  i_pmem_address = '0, d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic         i_pmem_resp, d_pmem_resp, mem_read, mem_write;
  logic [127:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic [15:0]  mem_address;
  logic         mem_resp = 1'b0;
  logic [127:0] mem_rdata = '0;

  l1_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic wr; logic [127:0] wdata; } mexp_t;
  typedef struct { logic is_d; logic [127:0] rdata; } rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];
  int n_cmp = 0, n_bad = 0;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] R1 = {8{16'h1111}}, R2 = {8{16'h2222}}, R3 = {8{16'h3333}};
  localparam logic [127:0] RF = {8{16'h5F5F}}, RT = {8{16'h6C6C}}, R9 = {8{16'h9999}};
  localparam logic [127:0] R71 = {8{16'h7171}}, WD = {8{16'hDEAD}}, WI = {8{16'hBEEF}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        mon_prev = 1'b0;
  logic [15:0] mon_held = '0;
  mexp_t       mon_m;
  rexp_t       mon_r;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        chk("strobe_excl", {127'b0, mem_read && mem_write}, '0);
        if (!mon_prev) begin
          if (mq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem_op: got addr %0h want none", mem_address);
          end else begin
            mon_m = mq.pop_front();
            chk("mem_addr", mem_address, mon_m.addr);
            chk("mem_write", mem_write, mon_m.wr);
            chk("mem_read", mem_read, !mon_m.wr);
            if (mon_m.wr) chk("mem_wdata", mem_wdata, mon_m.wdata);
          end
          mon_held = mem_address;
        end else chk("addr_hold", mem_address, mon_held);
      end
      mon_prev = mem_read || mem_write;
      if (i_pmem_resp && d_pmem_resp) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_excl: got both resp high want one");
      end else if (i_pmem_resp || d_pmem_resp) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b want none", i_pmem_resp, d_pmem_resp);
        end else begin
          mon_r = rq.pop_front();
          chk("resp_client", d_pmem_resp, mon_r.is_d);
          chk("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, mon_r.rdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (mem_read || mem_write) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_timeout: got no mem strobe want one within 20 cycles");
    end
  endtask

  task automatic pulse_resp(input logic [127:0] rd);
    mem_resp = 1'b1; mem_rdata = rd;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic serve(input int lat, input logic [127:0] rd);
    bit ok;
    wait_strobe(ok);
    if (ok) begin
      repeat (lat - 1) tick();
      pulse_resp(rd);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  int gap;
  bit ok;
  initial begin
    // reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_resp", i_pmem_resp, 0);
    chk("rst_d_resp", d_pmem_resp, 0);
    rst_n = 1'b1; tick();

    // icache-only fill
    mq.push_back('{16'h1230, 1'b0, '0}); rq.push_back('{1'b0, RD_A5});
    i_pmem_address = 16'h1230; i_pmem_read = 1'b1;
    tick();
    chk("fill_latency", mem_read, 1);
    serve(5, RD_A5);
    i_pmem_read = 1'b0;
    chk("i_resp_one_cycle", i_pmem_resp, 0);
    tick(); tick();

    // simultaneous requests from reset: i, then d, then d beats re-requesting i
    do_reset();
    mq.push_back('{16'h0100, 1'b0, '0}); rq.push_back('{1'b0, R1});
    mq.push_back('{16'h0200, 1'b0, '0}); rq.push_back('{1'b1, R2});
    mq.push_back('{16'h0300, 1'b0, '0}); rq.push_back('{1'b0, R3});
    i_pmem_address = 16'h0100; i_pmem_read = 1'b1;
    d_pmem_address = 16'h0200; d_pmem_read = 1'b1;
    tick();
    chk("both_i_first", mem_address, 16'h0100);
    serve(3, R1);
    i_pmem_address = 16'h0300;
    serve(3, R2);
    d_pmem_read = 1'b0;
    serve(2, R3);
    i_pmem_read = 1'b0;
    tick(); tick();

    // dcache writeback then fill
    mq.push_back('{16'h4000, 1'b1, WD}); rq.push_back('{1'b1, '0});
    mq.push_back('{16'h5000, 1'b0, '0}); rq.push_back('{1'b1, RF});
    d_pmem_address = 16'h4000; d_pmem_wdata = WD; d_pmem_write = 1'b1;
    serve(4, '0);
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 16'h5000;
    gap = 0;
    while (!(mem_read || mem_write) && gap < 10) begin gap++; tick(); end
    chk("wb_fill_gap", gap, 2);
    serve(3, RF);
    d_pmem_read = 1'b0;
    tick(); tick();

    // address toggling while granted
    mq.push_back('{16'h6000, 1'b0, '0}); rq.push_back('{1'b1, RT});
    d_pmem_address = 16'h6000; d_pmem_read = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      d_pmem_address = ~d_pmem_address;
      tick();
      chk("toggle_hold", mem_address, 16'h6000);
    end
    pulse_resp(RT);
    d_pmem_read = 1'b0;
    tick(); tick();

    // illegal read+write: issued as write
    mq.push_back('{16'h8000, 1'b1, WI}); rq.push_back('{1'b1, '0});
    d_pmem_address = 16'h8000; d_pmem_wdata = WI;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    tick();
    chk("illegal_as_write", {mem_write, mem_read}, 2'b10);
    serve(2, '0);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick(); tick();

    // client drops request while granted
    mq.push_back('{16'h9000, 1'b0, '0}); rq.push_back('{1'b0, R9});
    i_pmem_address = 16'h9000; i_pmem_read = 1'b1;
    tick();
    i_pmem_read = 1'b0;
    serve(3, R9);
    tick(); tick();

    // mem_resp in IDLE is ignored
    mem_resp = 1'b1; mem_rdata = R1;
    chk("idle_resp_i", i_pmem_resp, 0);
    chk("idle_resp_d", d_pmem_resp, 0);
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    tick();

    // reset mid-transaction: abandoned, then a fresh grant works
    mq.push_back('{16'h7000, 1'b0, '0});
    i_pmem_address = 16'h7000; i_pmem_read = 1'b1;
    wait_strobe(ok);
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("rst_async_drop", mem_read, 0);
    chk("rst_no_resp", i_pmem_resp, 0);
    i_pmem_read = 1'b0;
    tick(); tick();
    rst_n = 1'b1; tick();
    mq.push_back('{16'h7100, 1'b0, '0}); rq.push_back('{1'b0, R71});
    i_pmem_address = 16'h7100; i_pmem_read = 1'b1;
    tick();
    chk("post_rst_grant", {mem_read, mem_address}, {1'b1, 16'h7100});
    serve(3, R71);
    i_pmem_read = 1'b0;
    repeat (4) tick();

    chk("mq_drained", mq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Sits directly downstream of the two L1 cache controllers (instruction and data) and multiplexes their physical-memory (pmem) ports onto the single L2/physical-memory port.
- Grants one whole line transaction at a time (read fill or dirty writeback) and uses round-robin fairness.
- Latches the winning request into registers and routes the memory response back to the granted cache only.

Parameters:
ADDR_W, 16, line address width (lc3b_word)
LINE_W, 128, cache line width in bits (lc3b_block)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
i_pmem_read  in  1  icache line-fill request, level, held until i_pmem_resp
i_pmem_address  in  ADDR_W  icache line address
i_pmem_resp  out  1  one-cycle completion to icache
i_pmem_rdata  out  LINE_W  fill data to icache
d_pmem_read  in  1  dcache line-fill request, level
d_pmem_write  in  1  dcache writeback request, level
d_pmem_address  in  ADDR_W  dcache line address
d_pmem_wdata  in  LINE_W  dcache writeback line
d_pmem_resp  out  1  one-cycle completion to dcache
d_pmem_rdata  out  LINE_W  fill data to dcache
mem_read  out  1  registered read strobe to memory, held until mem_resp
mem_write  out  1  registered write strobe to memory, held until mem_resp
mem_address  out  ADDR_W  latched address
mem_wdata  out  LINE_W  latched writeback data
mem_resp  in  1  memory completion, one cycle
mem_rdata  in  LINE_W  memory read data, valid with mem_resp

Behaviour:
- Reset (async on rst_n low):
  - State goes to IDLE; prio goes to 0 (icache preferred).
  - mem_read, mem_write, i_pmem_resp and d_pmem_resp go to 0; mem_address and mem_wdata go to 0.
  - An in-flight memory transaction is abandoned and no client resp is issued.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - Compute req_i = i_pmem_read and req_d = d_pmem_read | d_pmem_write.
  - If only one request is present, it wins. If both are present, prio selects the winner (0 = icache, 1 = dcache).
  - On the granting edge, latch address, wdata and op, then move to GRANT_x. mem_read/mem_write assert from the next cycle, so the first memory strobe comes 1 cycle after the request is seen.
- GRANT_x:
  - Hold mem_* stable and ignore all client input changes.
  - When mem_resp=1:
    - Assert x_pmem_resp combinationally in the same cycle.
    - Drive x_pmem_rdata = mem_rdata in that cycle.
    - Deassert mem_read/mem_write at the clock edge and go to RELEASE.
    - Set prio to point at the other client.
- RELEASE:
  - One bubble cycle in which all requests are ignored, so a client's stale level request is not re-granted. Then go to IDLE.
  - Back-to-back transactions from one client (writeback followed by fill) therefore have a 2-cycle gap minimum between mem_resp and the next mem strobe.
- Ungranted client:
  - Its resp stays 0. Its rdata is a don't-care; drive it as mem_rdata ungated.
- d_pmem_read and d_pmem_write both high: illegal; treat the request as a write. A simulation assertion fires.
- Client drops its request while granted: the memory transaction still completes and the resp pulse is still issued.
- mem_resp while in IDLE or RELEASE: ignored; no client resp.
- mem_read and mem_write are never both 1. At most one x_pmem_resp is high in any cycle.

Decomposition:
- lc3b_types package holds lc3b_word and lc3b_block (widths 16/128) and a new enum arb_state_t {IDLE, GRANT_I, GRANT_D, RELEASE}.
- Optional sub-module: arb_req_latch, a registered address/wdata/op capture with a load enable, reusable by a future L2 victim buffer.
- The FSM and prio bit stay in the top module.

Test Plan:
- Icache-only fill:
  - Stimulus: i_pmem_read=1, addr 0x1230; mem_resp after 5 cycles with rdata 0xA5…A5.
  - Response: mem_read=1 from the next cycle with mem_address=0x1230; i_pmem_resp=1 for exactly one cycle carrying the rdata; d_pmem_resp stays 0.
- Simultaneous requests after reset:
  - Stimulus: icache read 0x0100 and dcache read 0x0200 asserted together.
  - Response: icache is served first; after RELEASE, dcache is served at 0x0200; a third simultaneous pair is served dcache-first.
- Dcache writeback then fill:
  - Stimulus: d_pmem_write with addr 0x4000 and wdata 0xDEAD…; on resp, switch to d_pmem_read 0x5000.
  - Response: mem_write=1 with the latched wdata, then a 2-cycle gap, then mem_read at 0x5000; no write/read overlap.
- Input changes while granted:
  - Stimulus: while GRANT_D, d_pmem_address toggles every cycle.
  - Response: mem_address holds the latched value until mem_resp.
- Reset mid-transaction:
  - Stimulus: rst_n low while GRANT_I, 3 cycles before mem_resp.
  - Response: mem_read drops asynchronously; no i_pmem_resp; after release, a new request is granted normally.
- Illegal dcache request:
  - Stimulus: d_pmem_read=d_pmem_write=1.
  - Response: the transaction is issued as a write and the assertion fires.
